regfile_mp_scoreboard: RTL
==========================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Multi-ported architectural register file for the dual-issue back end, with an integrated
//  busy-bit scoreboard. Provides READ_PORTS combinational reads with same-cycle write-through
//  bypass, WRITE_PORTS writeback ports, and per-register pending tracking set at issue and
//  cleared at writeback. Sits between dispatch (reads, issue marks) and writeback (writes).
// PARAMETERS
//  DATA_WIDTH   32  register width in bits
//  REG_NUM      32  number of architectural registers; reg 0 is hardwired zero
//  READ_PORTS   4   combinational read ports (2 per issue slot)
//  WRITE_PORTS  2   writeback ports
//  ISSUE_PORTS  2   destination-mark ports from dispatch
//  AW = $clog2(REG_NUM) (localparam)
// PORTS
//  clk         in   1                     clock
//  rst         in   1                     asynchronous reset, active-high
//  wr_en       in   WRITE_PORTS           writeback valid per port
//  wr_addr     in   WRITE_PORTS x AW      writeback destination
//  wr_data     in   WRITE_PORTS x DW      writeback data
//  rd_en       in   READ_PORTS            read enable per port
//  rd_addr     in   READ_PORTS x AW       read source address
//  rd_data     out  READ_PORTS x DW       read data (combinational)
//  rd_busy     out  READ_PORTS            source still pending (combinational)
//  iss_en      in   ISSUE_PORTS           mark destination pending
//  iss_addr    in   ISSUE_PORTS x AW      destination being issued
//  flush       in   1                     clear whole scoreboard (pipeline flush)
//  busy_vec    out  REG_NUM               registered scoreboard state
//  busy_cnt    out  $clog2(REG_NUM+1)     registered count of pending registers
// BEHAVIOUR
//  - Reset (async, while rst=1): all regs <= 0, busy_vec <= 0, busy_cnt <= 0; rd_data=0, rd_busy=0.
//  - Reg 0: writes ignored, never marked busy; read of addr 0 returns 0, rd_busy=0.
//  - Write: on posedge, for each wr_en port with addr!=0, regs[addr] <= wr_data.
//    Two ports same address same cycle: higher port index wins.
//  - Read (combinational): rd_en=0 -> data 0, busy 0. Else if any wr_en port matches rd_addr
//    (addr!=0) -> data of highest matching port index (bypass), rd_busy=0.
//    Else data=regs[rd_addr], rd_busy=busy_vec[rd_addr].
//  - Scoreboard next state, per reg r!=0, priority high to low:
//    1 flush=1 -> busy[r] <= 0 (flush overrides same-cycle issue and write)
//    2 any iss_en with iss_addr==r -> busy[r] <= 1 (new producer beats same-cycle writeback)
//    3 any wr_en with wr_addr==r -> busy[r] <= 0
//    4 else hold. Issue mark is visible on rd_busy the following cycle, not same cycle.
//  - Duplicate iss_addr on two issue ports: single set, no error.
//  - Write to non-busy reg: data written, busy unchanged (stays 0).
//  - busy_cnt <= popcount(next busy_vec); always equals popcount(busy_vec), max REG_NUM-1.
//  - Read latency 0; write-to-array latency 1 cycle (covered by bypass); scoreboard 1 cycle.
//  - Reset asserted mid-operation: same-cycle writes/issues discarded; state as reset above.
// STRUCTURE
//  - pipeline_types package: reg_addr_t, reg_data_t, rf_write_t {en,addr,data},
//    rf_issue_t {en,addr}; REG_NUM / DATA_WIDTH constants shared with dispatch.
//  - Sub-module rf_read_bypass: one instance per read port; takes write-port vector,
//    array read value and busy bit, produces rd_data/rd_busy with priority bypass.
//  - Top holds register array, scoreboard, popcount register.
// TESTING
//  1 Reset then read all ports addr 1..31 -> rd_data=0, rd_busy=0, busy_cnt=0.
//  2 wr0 r5=0xDEADBEEF, rd0 addr 5 same cycle -> 0xDEADBEEF; next cycle array read same value.
//  3 wr0 r7=0x11, wr1 r7=0x22 same cycle -> bypass 0x22; next cycle regs[7]=0x22.
//  4 iss r3 cycle N -> rd_busy(3)=0 at N, 1 at N+1, busy_cnt=1; wr r3=0x5 at N+2 -> rd 0x5,
//    busy 0 same cycle (bypass); busy_vec[3]=0 and busy_cnt=0 at N+3.
//  5 iss r9 and wr r9 same cycle with r9 busy -> busy_vec[9]=1 next cycle; iss r9 + flush ->
//    busy_vec=0, busy_cnt=0.
//  6 wr r0=0xFFFF and iss r0 -> read r0=0, busy_vec[0]=0; assert rst mid-burst of writes ->
//    all reads 0 immediately, busy_cnt=0.

Source files
------------

// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared types and sizing for the dual-issue register file and its busy-bit scoreboard.
package regfile_mp_scoreboard_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int REG_NUM     = 32;
  localparam int READ_PORTS  = 4;
  localparam int WRITE_PORTS = 2;
  localparam int ISSUE_PORTS = 2;
  localparam int AW          = $clog2(REG_NUM);
  localparam int CW          = $clog2(REG_NUM + 1);

  typedef logic [AW-1:0]         reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
    reg_data_t data;
  } rf_write_t;

  typedef struct packed {
    logic      en;
    reg_addr_t addr;
  } rf_issue_t;

  function automatic logic [CW-1:0] popcount(input logic [REG_NUM-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < REG_NUM; i++) c = c + CW'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Dispatch/writeback bus of the register file: reads, writebacks, issue marks, scoreboard view.
interface regfile_mp_scoreboard_if;
  import regfile_mp_scoreboard_pkg::*;

  logic      [WRITE_PORTS-1:0] wr_en;
  reg_addr_t [WRITE_PORTS-1:0] wr_addr;
  reg_data_t [WRITE_PORTS-1:0] wr_data;
  logic      [READ_PORTS-1:0]  rd_en;
  reg_addr_t [READ_PORTS-1:0]  rd_addr;
  reg_data_t [READ_PORTS-1:0]  rd_data;
  logic      [READ_PORTS-1:0]  rd_busy;
  logic      [ISSUE_PORTS-1:0] iss_en;
  reg_addr_t [ISSUE_PORTS-1:0] iss_addr;
  logic                        flush;
  logic      [REG_NUM-1:0]     busy_vec;
  logic      [CW-1:0]          busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_vec, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_vec, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_scoreboard_rf_read_bypass.sv
// One read port: array value and busy bit, overridden by a same-cycle writeback (highest port wins).
module rf_read_bypass
  import regfile_mp_scoreboard_pkg::*;
(
  input  rf_write_t [WRITE_PORTS-1:0] wr,
  input  logic                        rd_en,
  input  reg_addr_t                   rd_addr,
  input  reg_data_t                   arr_data,
  input  logic                        arr_busy,
  output reg_data_t                   rd_data,
  output logic                        rd_busy
);
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_en) begin
      rd_data = arr_data;
      rd_busy = arr_busy;
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr[w].en && wr[w].addr == rd_addr && rd_addr != '0) begin
          rd_data = wr[w].data;
          rd_busy = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-ported register file with write-through bypass and per-register pending scoreboard.
module regfile_mp_scoreboard
  import regfile_mp_scoreboard_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  regfile_mp_scoreboard_if.slave  bus
);
  reg_data_t                   regs [REG_NUM];
  logic      [REG_NUM-1:0]     busy_q;
  logic      [REG_NUM-1:0]     busy_nxt;
  logic      [CW-1:0]          cnt_q;
  logic      [REG_NUM-1:0]     iss_hit;
  logic      [REG_NUM-1:0]     wr_hit;
  rf_write_t [WRITE_PORTS-1:0] wr_vec;
  rf_issue_t [ISSUE_PORTS-1:0] iss_vec;
  reg_data_t [READ_PORTS-1:0]  rd_data_w;
  logic      [READ_PORTS-1:0]  rd_busy_w;

  // Bypass is masked during reset so reads return zero immediately.
  always_comb begin
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_vec[w].en   = bus.wr_en[w] & ~rst;
      wr_vec[w].addr = bus.wr_addr[w];
      wr_vec[w].data = bus.wr_data[w];
    end
    for (int i = 0; i < ISSUE_PORTS; i++) begin
      iss_vec[i].en   = bus.iss_en[i];
      iss_vec[i].addr = bus.iss_addr[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_vec[w].en && wr_vec[w].addr != '0) regs[wr_vec[w].addr] <= wr_vec[w].data;
      end
    end
  end

  always_comb begin
    iss_hit = '0;
    wr_hit  = '0;
    for (int i = 0; i < ISSUE_PORTS; i++)
      if (iss_vec[i].en) iss_hit[iss_vec[i].addr] = 1'b1;
    for (int w = 0; w < WRITE_PORTS; w++)
      if (wr_vec[w].en) wr_hit[wr_vec[w].addr] = 1'b1;
  end

  // Flush beats a new producer, which beats a same-cycle writeback.
  always_comb begin
    busy_nxt = busy_q;
    for (int r = 1; r < REG_NUM; r++) begin
      if (bus.flush)      busy_nxt[r] = 1'b0;
      else if (iss_hit[r]) busy_nxt[r] = 1'b1;
      else if (wr_hit[r])  busy_nxt[r] = 1'b0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= popcount(busy_nxt);
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    rf_read_bypass u_rd (
      .wr       (wr_vec),
      .rd_en    (bus.rd_en[p]),
      .rd_addr  (bus.rd_addr[p]),
      .arr_data (regs[bus.rd_addr[p]]),
      .arr_busy (busy_q[bus.rd_addr[p]]),
      .rd_data  (rd_data_w[p]),
      .rd_busy  (rd_busy_w[p])
    );
  end

  assign bus.rd_data  = rd_data_w;
  assign bus.rd_busy  = rd_busy_w;
  assign bus.busy_vec = busy_q;
  assign bus.busy_cnt = cnt_q;
endmodule
